// File: rtl/fifo_serializer_if.sv
// FIFO-side and serial-side handshake signals of the FIFO drain serializer.
// master = serializer, slave = FIFO plus serial sink.
interface fifo_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_pop;
  logic             ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;

  modport master (
    input  fifo_empty, fifo_data, ser_ready,
    output fifo_pop, ser_data, ser_valid, ser_last
  );

  modport slave (
    output fifo_empty, fifo_data, ser_ready,
    input  fifo_pop, ser_data, ser_valid, ser_last
  );
endinterface

// File: rtl/fifo_serializer.sv
// Drains words from a registered-output FIFO and shifts them out one bit per
// valid/ready handshake, flagging the last bit and counting completed words.
module fifo_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  output logic               busy,
  output logic [7:0]         word_cnt,
  fifo_serializer_if.master  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [7:0]         wcnt_d;
  logic               pop_d, valid_d, data_d, last_d, busy_d;
  logic               start_c, hs_c;

  // State, datapath and output registers; outputs are decoded from next state
  // so they behave as Moore outputs while still coming straight from flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      word_cnt      <= '0;
      bus.fifo_pop  <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.ser_data  <= 1'b0;
      bus.ser_last  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      word_cnt      <= wcnt_d;
      bus.fifo_pop  <= pop_d;
      bus.ser_valid <= valid_d;
      bus.ser_data  <= data_d;
      bus.ser_last  <= last_d;
      busy          <= busy_d;
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    wcnt_d   = word_cnt;
    start_c  = en && !bus.fifo_empty;
    hs_c     = (state_q == SHIFT) && bus.ser_ready;

    case (state_q)
      IDLE: begin
        if (start_c) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d  = bus.fifo_data;
        bitcnt_d = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (hs_c) begin
          shreg_d  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == LAST_BIT) begin
            // Clear explicitly so non-power-of-two widths never overrun.
            bitcnt_d = '0;
            wcnt_d   = word_cnt + 8'd1;
            state_d  = start_c ? POP : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    pop_d   = (state_d == POP);
    valid_d = (state_d == SHIFT);
    busy_d  = (state_d != IDLE);
    data_d  = valid_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
    last_d  = valid_d && (bitcnt_d == LAST_BIT);
  end

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
Downstream drain stage for the team's push/pop FIFO. When enabled and the FIFO is non-empty, it pops one word, captures it from the FIFO's registered output one cycle later, and shifts it out one bit per handshake on a valid/ready serial port. It marks the last bit of each word and counts completed words.

Parameters:
WIDTH, 4, word width; must equal the upstream FIFO data width; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
en  input  1  drain enable; sampled only in IDLE and at word end.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  WIDTH  FIFO registered output; valid the cycle after fifo_pop.
fifo_pop  output  1  pop strobe to the FIFO.
ser_data  output  1  current serial bit.
ser_valid  output  1  ser_data is valid.
ser_ready  input  1  sink accepts the bit at the clock edge when ser_valid && ser_ready.
ser_last  output  1  current bit is the final bit of the word.
busy  output  1  high in any state other than IDLE.
word_cnt  output  8  count of fully transmitted words; wraps 255 -> 0.

Behaviour:
- Reset (async, rstn=0): state=IDLE, shift register=0, bit counter=0, word_cnt=0. fifo_pop, ser_valid, ser_last, ser_data and busy are all 0 while in reset and on the first cycle after release.
- FSM states: IDLE, POP, LOAD, SHIFT. All outputs are Moore outputs, decoded from state and registers.
- IDLE: when en && !fifo_empty, go to POP. Otherwise stay.
- POP: fifo_pop=1 for exactly one cycle. Unconditionally go to LOAD.
- LOAD: fifo_data is valid this cycle. Capture it into the shift register, clear the bit counter, go to SHIFT. fifo_pop=0.
- SHIFT: ser_valid=1.
  - ser_data = shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0.
  - ser_last = (bitcnt == WIDTH-1).
  - On a handshake: shift toward the output end (zero fill) and increment bitcnt.
  - If the handshake is on the last bit: increment word_cnt, then go to POP if en && !fifo_empty, else go to IDLE.
  - Without a handshake, ser_data, ser_valid and ser_last hold stable (AXI-style rule; valid is never withdrawn).
- Bit counter width is $clog2(WIDTH). It never exceeds WIDTH-1.
- Minimum word period is WIDTH+2 cycles (POP, LOAD, then WIDTH SHIFT cycles with ser_ready held high).
- Back-to-back words: POP is asserted on the cycle immediately after the last-bit handshake. Between words ser_valid is low for exactly 2 cycles (POP, LOAD).
- en deasserted mid-word: the current word completes. No further pop occurs.
- fifo_empty is ignored outside IDLE and the last-bit handshake. This block is the FIFO's only consumer, so the FIFO cannot empty between the decision and the pop.
- fifo_pop is never asserted while fifo_empty was high at the deciding edge. The FIFO is never underflowed.
- Reset mid-word: the partial word is discarded, state returns to IDLE, and ser_valid drops immediately (asynchronous).

Test Plan:
1. WIDTH=4, MSB_FIRST=1, FIFO holds 4'hA, en=1, ser_ready=1 -> fifo_pop high for 1 cycle. Two cycles later ser_data sequence is 1,0,1,0 on consecutive cycles, ser_last high only on the 4th bit, word_cnt goes 0->1, FSM returns to IDLE.
2. Backpressure: word 4'hC, ser_ready low for 3 cycles while the 2nd bit is presented -> ser_data=1, ser_valid=1, ser_last=0 held stable all 3 cycles. Full sequence is still 1,1,0,0.
3. Back-to-back: FIFO holds 4'h9 then 4'h6, ser_ready=1 -> bits 1,0,0,1 then 0,1,1,0, with exactly 2 idle-valid cycles between words. fifo_pop pulses twice. word_cnt=2. Total 12 cycles from the first pop.
4. en dropped during the 2nd bit of word 4'h5 with a second word queued -> 4'h5 completes (0,1,0,1), no second pop, busy falls, word_cnt=1.
5. MSB_FIRST=0, word 4'h1 -> bit sequence 1,0,0,0, ser_last on the 4th bit.
6. rstn pulsed low during the 3rd bit of 4'hF -> ser_valid goes to 0 immediately, word_cnt=0, state is IDLE. After release with the FIFO empty, fifo_pop stays 0 indefinitely.
